// File: rtl/contador_param.sv
// contador_param: up/down counter with wrap, saturate and one-shot modes plus parallel load.
module contador_param #(
   parameter int               WIDTH   = 8,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic             up,
   input  logic [1:0]       mode,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic [WIDTH-1:0] max_val,
   output logic [WIDTH-1:0] out,
   output logic             cout,
   output logic             at_limit,
   output logic             done
);
   typedef enum logic {ARMED, DONE} state_t;
   state_t state_q, state_d;
   logic [WIDTH-1:0] out_q, out_d;
   logic cout_q, cout_d, done_q;
   logic one_shot, wrap, top, bot;
   assign one_shot = mode == 2'b10;
   assign wrap     = ~(mode[1] ^ mode[0]);
   assign top      = out_q >= max_val;
   assign bot      = out_q == '0;
   assign at_limit = up ? out_q == max_val : bot;
   assign out      = out_q;
   assign cout     = cout_q;
   assign done     = done_q;
   // leaving one-shot mode releases DONE and steps under the new mode on the same edge
   always_comb begin
      out_d   = out_q;
      cout_d  = 1'b0;
      state_d = one_shot ? state_q : ARMED;
      if (load) begin
         out_d   = load_val;
         state_d = ARMED;
      end else if (enable && !(one_shot && state_q == DONE)) begin
         if (one_shot && at_limit) begin
            cout_d  = 1'b1;
            state_d = DONE;
         end else if (up) begin
            out_d  = top ? (wrap ? '0 : max_val) : out_q + 1'b1;
            cout_d = wrap && top;
         end else begin
            out_d  = bot ? (wrap ? max_val : '0) : out_q - 1'b1;
            cout_d = wrap && bot;
         end
      end
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_q   <= RST_VAL;
         cout_q  <= 1'b0;
         done_q  <= 1'b0;
         state_q <= ARMED;
      end else begin
         out_q   <= out_d;
         cout_q  <= cout_d;
         done_q  <= state_d == DONE;
         state_q <= state_d;
      end
   end
endmodule

// File: tb/tb_contador_param.sv
// tb_contador_param: directed vectors with a queue scoreboard checking every post-edge output.
module tb_contador_param;
   logic clk, rst, enable, up, load, cout, at_limit, done;
   logic [1:0] mode;
   logic [7:0] load_val, max_val, out;
   int checks = 0, failures = 0;
   typedef struct {
      logic [7:0] o;
      logic c, d, al;
      string nm;
   } exp_t;
   exp_t q[$];

   contador_param #(.WIDTH(8), .RST_VAL(8'd3)) dut (
      .clk(clk), .rst(rst), .enable(enable), .up(up), .mode(mode), .load(load),
      .load_val(load_val), .max_val(max_val), .out(out), .cout(cout),
      .at_limit(at_limit), .done(done)
   );

   always #5 clk = ~clk;

   function automatic exp_t mk(input logic [7:0] eo, input logic ec, input logic ed, input string nm);
      exp_t e;
      e.o = eo; e.c = ec; e.d = ed; e.nm = nm;
      e.al = up ? (eo == max_val) : (eo == 8'd0);
      return e;
   endfunction

   task automatic chk(input exp_t e);
      checks++;
      if ({out, cout, done, at_limit} !== {e.o, e.c, e.d, e.al}) begin
         failures++;
         $display("FAIL %s: got out=%0d cout=%b done=%b at_limit=%b, want out=%0d cout=%b done=%b at_limit=%b",
                  e.nm, out, cout, done, at_limit, e.o, e.c, e.d, e.al);
      end
   endtask

   task automatic expect_step(input logic [7:0] eo, input logic ec, input logic ed, input string nm);
      q.push_back(mk(eo, ec, ed, nm));
      @(posedge clk); #2;
   endtask

   task automatic do_load(input logic [7:0] v, input string nm);
      load = 1'b1; load_val = v;
      expect_step(v, 1'b0, 1'b0, nm);
      load = 1'b0;
   endtask

   // monitor: one registered result per edge, judged 1 time unit after it
   initial begin
      forever begin
         @(posedge clk); #1;
         if (q.size() != 0) chk(q.pop_front());
      end
   end

   initial begin
      clk = 0; rst = 1; enable = 0; up = 0; mode = 2'b00; load = 0; load_val = 0; max_val = 0;
      #2 chk(mk(8'd3, 1'b0, 1'b0, "reset"));
      @(negedge clk) rst = 0;
      @(posedge clk); #2;
      expect_step(8'd3, 0, 0, "hold");
      // full wrap up over 256 steps
      max_val = 8'd255; up = 1;
      do_load(8'd0, "load0");
      enable = 1;
      for (int i = 1; i < 256; i++) expect_step(8'(i), 0, 0, "wrap_up");
      expect_step(8'd0, 1, 0, "wrap_up_roll");
      expect_step(8'd1, 0, 0, "wrap_up_after");
      // wrap down
      max_val = 8'd9; up = 0;
      do_load(8'd2, "load2");
      expect_step(8'd1, 0, 0, "wrap_dn1");
      expect_step(8'd0, 0, 0, "wrap_dn0");
      expect_step(8'd9, 1, 0, "wrap_dn_roll");
      expect_step(8'd8, 0, 0, "wrap_dn8");
      enable = 0;
      expect_step(8'd8, 0, 0, "hold_en0");
      // saturate
      enable = 1; mode = 2'b01; max_val = 8'd5; up = 1;
      do_load(8'd3, "load3");
      expect_step(8'd4, 0, 0, "sat_up4");
      for (int i = 0; i < 4; i++) expect_step(8'd5, 0, 0, "sat_up5");
      up = 0;
      do_load(8'd1, "load1");
      expect_step(8'd0, 0, 0, "sat_dn0");
      expect_step(8'd0, 0, 0, "sat_dn_hold");
      // one-shot up
      mode = 2'b10; max_val = 8'd3; up = 1;
      do_load(8'd0, "os_load0");
      expect_step(8'd1, 0, 0, "os1");
      expect_step(8'd2, 0, 0, "os2");
      expect_step(8'd3, 0, 0, "os3");
      expect_step(8'd3, 1, 1, "os_fire");
      expect_step(8'd3, 0, 1, "os_done5");
      expect_step(8'd3, 0, 1, "os_done6");
      up = 0;
      expect_step(8'd3, 0, 1, "os_done_dn");
      up = 1;
      do_load(8'd1, "os_reload");
      expect_step(8'd2, 0, 0, "os2b");
      expect_step(8'd3, 0, 0, "os3b");
      expect_step(8'd3, 1, 1, "os_fire_b");
      mode = 2'b00;
      expect_step(8'd0, 1, 0, "os_exit_wrap");
      // one-shot down
      mode = 2'b10; up = 0;
      do_load(8'd2, "os_dn_load");
      expect_step(8'd1, 0, 0, "os_dn1");
      expect_step(8'd0, 0, 0, "os_dn0");
      expect_step(8'd0, 1, 1, "os_dn_fire");
      // load above max_val
      mode = 2'b00; max_val = 8'd100; up = 1;
      do_load(8'd200, "load200");
      expect_step(8'd0, 1, 0, "above_max_up");
      up = 0;
      do_load(8'd200, "load200b");
      expect_step(8'd199, 0, 0, "above_max_dn");
      mode = 2'b01;
      expect_step(8'd198, 0, 0, "above_max_sat_dn");
      // max_val = 0 and mode 11
      mode = 2'b00; max_val = 8'd0; up = 1;
      do_load(8'd0, "max0_load");
      expect_step(8'd0, 1, 0, "max0_up");
      expect_step(8'd0, 1, 0, "max0_up2");
      up = 0;
      expect_step(8'd0, 1, 0, "max0_dn");
      mode = 2'b11; max_val = 8'd4; up = 1;
      do_load(8'd4, "m11_load");
      expect_step(8'd0, 1, 0, "m11_wrap");
      // async reset while DONE with out=7, then rst beats load
      mode = 2'b10; max_val = 8'd7; up = 1;
      do_load(8'd7, "pre_rst_load");
      expect_step(8'd7, 1, 1, "pre_rst_done");
      #2 rst = 1;
      #1 chk(mk(8'd3, 1'b0, 1'b0, "async_rst"));
      load = 1; load_val = 8'd9;
      @(posedge clk); #1;
      chk(mk(8'd3, 1'b0, 1'b0, "rst_over_load"));
      #1 rst = 0; load = 0; mode = 2'b00; max_val = 8'd20;
      expect_step(8'd4, 0, 0, "post_rst");
      enable = 0;
      for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
      if (q.size() != 0) begin
         checks++; failures++;
         $display("FAIL drain: %0d results still pending, want 0", q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/contador_param.md
CONTADOR_PARAM -- requirements
Module: contador_param

Interface
REQ-001 SHALL have parameter WIDTH, default 8, counter width in bits (legal 2..32).
REQ-002 SHALL have parameter RST_VAL, default 0, value loaded into out on reset (WIDTH bits).
REQ-003 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port enable  input  1  count-step qualifier.
REQ-006 SHALL have port up  input  1  direction: 1 = increment, 0 = decrement.
REQ-007 SHALL have port mode  input  2  00 = wrap, 01 = saturate, 10 = one-shot, 11 = treated as wrap.
REQ-008 SHALL have port load  input  1  synchronous parallel load strobe.
REQ-009 SHALL have port load_val  input  WIDTH  value written on load.
REQ-010 SHALL have port max_val  input  WIDTH  upper terminal value (count range 0..max_val).
REQ-011 SHALL have port out  output  WIDTH  registered count value.
REQ-012 SHALL have port cout  output  1  registered one-cycle carry/borrow pulse.
REQ-013 SHALL have port at_limit  output  1  combinational: out == max_val when up=1, out == 0 when up=0.
REQ-014 SHALL have port done  output  1  registered, high while the one-shot FSM is in DONE.

Function
REQ-015 SHALL apply per-cycle priority rst > load > enable step > hold.
REQ-016 SHALL on load write out = load_val, force cout = 0 and move FSM to ARMED, regardless of enable, mode or FSM state.
REQ-017 SHALL hold out and drive cout = 0 in any cycle with enable = 0 and load = 0.
REQ-018 SHALL in wrap mode, up: out < max_val -> out+1; out >= max_val -> 0 with cout = 1 for that cycle.
REQ-019 SHALL in wrap mode, down: out > 0 -> out-1; out == 0 -> max_val with cout = 1 for that cycle.
REQ-020 SHALL in saturate mode, up: out < max_val -> out+1; out >= max_val -> out = max_val; cout stays 0.
REQ-021 SHALL in saturate mode, down: out > 0 -> out-1; out == 0 -> hold 0; cout stays 0.
REQ-022 SHALL decrement normally from out > max_val (e.g. after load or a max_val change) in every mode.
REQ-023 SHALL implement a two-state one-shot FSM: ARMED and DONE; reset state ARMED.
REQ-024 SHALL in one-shot mode, state ARMED, step as in saturate mode; a step taken with at_limit = 1 leaves out unchanged, pulses cout = 1 for that cycle and moves to DONE.
REQ-025 SHALL in DONE ignore enable and up, hold out, keep cout = 0 and drive done = 1.
REQ-026 SHALL leave DONE only on load (-> ARMED) or on mode != 10 (-> ARMED on next edge, step behaviour per new mode from that same edge).
REQ-027 SHALL keep the FSM in ARMED whenever mode != 10.
REQ-028 SHALL sample mode, up and max_val each cycle; changes take effect on the next rising edge.
REQ-029 SHALL with max_val = 0 keep out = 0 (from 0), pulsing cout on every enabled step in wrap mode.
REQ-030 SHALL perform all arithmetic modulo 2^WIDTH with no internal width growth visible at out.

Reset
REQ-031 SHALL, while rst = 1, asynchronously force out = RST_VAL, cout = 0, done = 0, FSM = ARMED, independent of clk.
REQ-032 SHALL, when rst asserts mid-count or in DONE, discard the in-flight step; first step after deassertion starts from RST_VAL.
REQ-033 SHALL apply rst deassertion synchronously to clk for release of the state registers.

Verification
REQ-034 SHALL cover: WIDTH=8, max_val=255, mode=00, up=1, enable=1 from 0 for 256 cycles -> out 255 then 0, cout high exactly on the 0 cycle.
REQ-035 SHALL cover: max_val=9, mode=00, up=0, load_val=2, load then 3 steps -> out 1, 0, 9; cout high on the 9 cycle only.
REQ-036 SHALL cover: max_val=5, mode=01, up=1, load_val=3, 5 steps -> out 4, 5, 5, 5, 5; cout never high; at_limit high from out=5.
REQ-037 SHALL cover: max_val=3, mode=10, up=1 from 0, 6 steps -> out 1, 2, 3, 3; cout pulse on 4th step; done high after; load_val=1 with load -> out 1, done 0.
REQ-038 SHALL cover: rst pulse between clock edges while out=7 -> out=RST_VAL and done=0 immediately, before next clk edge; load and rst together -> rst wins.
REQ-039 SHALL cover: load_val=200, max_val=100, mode=00, up=1, one step -> out 0 with cout=1; same with up=0 -> out 199, cout=0.
